// File: rtl/mux4_rr_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | mux4_rr_arbiter_pkg                                                      |
// | Shared state encoding and requester-to-mux-select mapping for the        |
// | round-robin arbiter in front of the 4:1 mux.                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package mux4_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // The mux routes i[3] on select 00 and i[0] on select 11.
  localparam logic [1:0] c_SEL_REQ3 = 2'b00;
  localparam logic [1:0] c_SEL_REQ2 = 2'b01;
  localparam logic [1:0] c_SEL_REQ1 = 2'b10;
  localparam logic [1:0] c_SEL_REQ0 = 2'b11;

  function automatic logic [1:0] enc_sel(input logic [1:0] idx);
    logic [1:0] sel;
    case (idx)
      2'd0:    sel = c_SEL_REQ0;
      2'd1:    sel = c_SEL_REQ1;
      2'd2:    sel = c_SEL_REQ2;
      default: sel = c_SEL_REQ3;
    endcase
    return sel;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_rr_arbiter_pick.sv
// +--------------------------------------------------------------------------+
// | rr_pick4                                                                 |
// | Combinational round-robin pick: first set request scanning from ptr.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       found_o,
  output logic [1:0] winner_o
);

  logic [1:0] w_idx;

  // Scan from the far end so the position nearest ptr is written last and wins.
  always_comb begin
    found_o  = 1'b0;
    winner_o = 2'd0;
    w_idx    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = ptr_i + 2'(k);
      if (req_i[w_idx]) begin
        found_o  = 1'b1;
        winner_o = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | mux4_rr_arbiter                                                          |
// | Round-robin owner selection, mux select drive and burst hold for the     |
// | shared 4:1 mux output channel.                                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_i,
  input  logic [3:0]       last_i,
  input  logic             out_ready_i,
  output logic [3:0]       gnt_o,
  output logic             sel2_o,
  output logic             sel1_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] beat_cnt_o
);

  localparam logic [CNT_W-1:0] c_MAX_HOLD = CNT_W'(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_accept;
  logic             w_release;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [3:0]       w_pick_req;
  logic [1:0]       w_pick_ptr;
  logic             w_found;
  logic [1:0]       w_winner;

  // On a release the old owner is masked and scanning starts just past it.
  assign w_pick_req = (state_q == OWN) ? (req_i & ~onehot4(owner_q)) : req_i;
  assign w_pick_ptr = (state_q == OWN) ? (owner_q + 2'd1) : ptr_q;

  rr_pick4 u_pick (
    .req_i    (w_pick_req),
    .ptr_i    (w_pick_ptr),
    .found_o  (w_found),
    .winner_o (w_winner)
  );

  assign out_valid_o = |(gnt_q & req_i);
  assign w_accept    = out_valid_o && out_ready_i;
  assign w_cnt_inc   = (cnt_q >= c_MAX_HOLD) ? cnt_q : (cnt_q + CNT_W'(1));

  assign w_release = (state_q == OWN) &&
                     (!req_i[owner_q] ||
                      (w_accept && (last_i[owner_q] || (w_cnt_inc == c_MAX_HOLD))));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (w_found) begin
          state_d = OWN;
          gnt_d   = onehot4(w_winner);
          sel_d   = enc_sel(w_winner);
          owner_d = w_winner;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (w_accept) begin
          cnt_d = w_cnt_inc;
        end
        if (w_release) begin
          ptr_d = owner_q + 2'd1;
          if (w_found) begin
            gnt_d   = onehot4(w_winner);
            sel_d   = enc_sel(w_winner);
            owner_d = w_winner;
            cnt_d   = '0;
          end else begin
            // sel keeps pointing at the old owner while nobody holds the channel.
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign sel2_o     = sel_q[1];
  assign sel1_o     = sel_q[0];
  assign busy_o     = (state_q == OWN);
  assign beat_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_mux4_rr_arbiter                                                       |
// | Scoreboard bench: per-cycle expected outputs from a behavioural model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mux4_rr_arbiter;

  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] last = 4'b0000;
  logic       out_ready = 1'b0;
  logic [3:0] gnt;
  logic       sel2, sel1, out_valid, busy;
  logic [7:0] beat_cnt;

  mux4_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .last_i      (last),
    .out_ready_i (out_ready),
    .gnt_o       (gnt),
    .sel2_o      (sel2),
    .sel1_o      (sel1),
    .out_valid_o (out_valid),
    .busy_o      (busy),
    .beat_cnt_o  (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gnt;
    int sel;
    int busy;
    int cnt;
    int ov;
  } snap_t;

  snap_t q[$];
  int n_vec = 0;
  int n_mis = 0;

  // Model state: owner index (-1 = none), rotation start, beat count, last select.
  int m_owner = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_sel = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (start + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_sel   = 0;
  endtask

  // Apply one cycle of inputs, queue the expected outputs, advance the model.
  task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic rdy);
    snap_t e;
    int n_owner, n_ptr, n_cnt, n_sel, w;
    logic acc, rel;
    req = r;
    last = l;
    out_ready = rdy;
    e.gnt  = (m_owner >= 0) ? (1 << m_owner) : 0;
    e.sel  = m_sel;
    e.busy = (m_owner >= 0) ? 1 : 0;
    e.cnt  = m_cnt;
    e.ov   = (m_owner >= 0 && r[m_owner]) ? 1 : 0;
    q.push_back(e);

    n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt; n_sel = m_sel;
    if (m_owner < 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        n_owner = w; n_sel = 3 - w; n_cnt = 0;
      end
    end else begin
      acc = r[m_owner] && rdy;
      if (acc) n_cnt = (m_cnt + 1 > MAXH) ? MAXH : m_cnt + 1;
      rel = !r[m_owner] || (acc && (l[m_owner] || n_cnt == MAXH));
      if (rel) begin
        n_ptr = (m_owner + 1) % 4;
        w = pick(r & ~(4'b0001 << m_owner), n_ptr);
        if (w >= 0) begin
          n_owner = w; n_sel = 3 - w; n_cnt = 0;
        end else begin
          n_owner = -1;
        end
      end
    end
    @(posedge clk);
    #1;
    m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt; m_sel = n_sel;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      snap_t e;
      e = q.pop_front();
      chk("gnt", int'(gnt), e.gnt);
      chk("sel", int'({sel2, sel1}), e.sel);
      chk("busy", int'(busy), e.busy);
      chk("beat_cnt", int'(beat_cnt), e.cnt);
      chk("out_valid", int'(out_valid), e.ov);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_sel", int'({sel2, sel1}), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single-beat burst from requester 0.
    cycle(4'b0001, 4'b0001, 1'b1);
    chk("t1_gnt", int'(gnt), 1);
    chk("t1_sel", int'({sel2, sel1}), 3);
    cycle(4'b0001, 4'b0001, 1'b1);
    chk("t1_idle_gnt", int'(gnt), 0);
    cycle(4'b0000, 4'b0000, 1'b1);

    // Back-to-back one-beat grants in rotation order.
    for (int i = 0; i < 10; i++) cycle(4'b1111, 4'b1111, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    // Beat limit with the request held.
    for (int i = 0; i < 14; i++) cycle(4'b0100, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    // Long stall while requester 1 owns.
    cycle(4'b0010, 4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) cycle(4'b1111, 4'b0000, 1'b0);
    chk("t4_gnt", int'(gnt), 2);
    for (int i = 0; i < 4; i++) cycle(4'b1111, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    // Requester 3 drops its request after three beats.
    cycle(4'b1000, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b1000, 4'b0000, 1'b1);
    chk("t5_cnt", int'(beat_cnt), 3);
    cycle(4'b0001, 4'b0000, 1'b1);
    chk("t5_gnt", int'(gnt), 1);
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r, l;
      logic rd;
      r  = 4'($urandom_range(0, 15));
      l  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rd = ($urandom_range(0, 9) < 7);
      cycle(r, l, rd);
    end

    // Asynchronous reset in the middle of a requester 2 burst.
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b1);
    chk("t6_pre_gnt", int'(gnt), 4);
    rst = 1'b1;
    #1;
    chk("t6_async_gnt", int'(gnt), 0);
    chk("t6_async_busy", int'(busy), 0);
    chk("t6_async_sel", int'({sel2, sel1}), 0);
    @(posedge clk); #1;
    chk("t6_hold_gnt", int'(gnt), 0);
    rst = 1'b0;
    model_reset();
    cycle(4'b0110, 4'b0000, 1'b1);
    chk("t6_first_gnt", int'(gnt), 2);
    for (int i = 0; i < 6; i++) cycle(4'b0110, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    @(negedge clk); #1;
    chk("queue_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
